rom_read_sequencer: RTL
=======================

Name: rom_read_sequencer

Overview:
- Upstream address/control stage of the ROM reader: on `start`, walks every ROM address from 0 to 2^ADDR_WIDTH-1.
- Drives `rom_cs_n`/`rom_oe_n` with programmable access wait states and captures each data byte.
- Hands each byte downstream over a valid/ready handshake.
- `address_line` drives both the ROM socket and the address display stage, so the display always shows the address being read.

Parameters:
ADDR_WIDTH, 9, ROM address width; last address = 2^ADDR_WIDTH-1 (511).
DATA_WIDTH, 8, ROM data width.
ACCESS_CYCLES, 4, cycles `rom_oe_n` is held low before sampling; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  1-cycle request to begin a full sweep; honoured only in IDLE.
address_line  output  ADDR_WIDTH  current ROM address; to ROM pins and address display.
rom_cs_n  output  1  ROM chip select, active low.
rom_oe_n  output  1  ROM output enable, active low.
rom_data  input  DATA_WIDTH  ROM data bus.
data_out  output  DATA_WIDTH  captured byte.
data_valid  output  1  `data_out` valid; held until accepted.
data_ready  input  1  downstream accepts on `data_valid && data_ready`.
busy  output  1  high in every state except IDLE.
done  output  1  1-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (sync, also mid-sweep):
  - State = IDLE, `address_line` = 0, `rom_cs_n` = 1, `rom_oe_n` = 1.
  - `data_out` = 0, `data_valid` = 0, `busy` = 0, `done` = 0, wait counter = 0.
  - Any byte held in HOLD is discarded.
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE:
  - `cs_n` = 1, `oe_n` = 1.
  - `address_line` keeps its last value, so the display holds the final address.
  - `start` = 1: `address_line` <= 0, go to SETUP.
- SETUP (exactly 1 cycle): `cs_n` = 0, `oe_n` = 1, address stable; go to ACCESS with counter <= 0.
- ACCESS:
  - `cs_n` = 0, `oe_n` = 0.
  - Counter increments each cycle; stays ACCESS_CYCLES cycles.
  - On the cycle counter == ACCESS_CYCLES-1: `data_out` <= `rom_data`, `data_valid` <= 1, go to HOLD.
- HOLD:
  - `cs_n` = 0, `oe_n` = 1.
  - `data_valid` = 1 and `data_out` held stable until `data_ready`.
  - On handshake, `data_valid` <= 0, then:
    - if `address_line` == 2^ADDR_WIDTH-1, go to DONE;
    - else `address_line` <= `address_line` + 1, go to SETUP.
  - No wrap past the last address.
- DONE (1 cycle): `done` = 1, `cs_n` = 1, `oe_n` = 1; then IDLE.
- Throughput with `data_ready` tied high: ACCESS_CYCLES+2 cycles per byte.
  - Full 512-byte sweep at default = 3072 cycles from SETUP entry to DONE entry.
- `start` while `busy` = 1 is ignored, with no effect on state, address or outputs.
- `start` asserted in the same cycle as `reset`: reset wins.
- `data_ready` high outside HOLD has no effect.
- `rom_data` is sampled only on the final ACCESS cycle.

Optional Feature:
- Macro: ROM_READ_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` [15:0]: 16-bit modulo-2^16 sum of every byte accepted by handshake.
  - Cleared to 0 on reset and on an honoured `start`.
  - Updated in the handshake cycle; value is final when `done` pulses and held through IDLE.
- Not defined: the `checksum` port and adder are absent; all other behaviour is identical.

Test Plan:
1. Reset, then idle 10 cycles -> `address_line` = 0, `cs_n` = `oe_n` = 1, `data_valid` = 0, `busy` = 0, `done` = 0 throughout.
2. `start` pulse, ROM model data = 8'h5A, `data_ready` = 1 -> `busy` rises next cycle; `oe_n` low exactly 4 cycles; `data_valid` for 1 cycle with `data_out` = 8'h5A; `address_line` = 1 six cycles after SETUP entry.
3. Backpressure: `data_ready` = 0 for 20 cycles at address 3 -> `data_valid` stays 1, `data_out` stable, `address_line` stays 3, `oe_n` = 1; on `data_ready` = 1, address advances to 4.
4. Full sweep, ROM model data = addr[7:0], `data_ready` = 1 -> 512 transfers in order, last `address_line` = 511, `done` single pulse at cycle 3072 after first SETUP; with ROM_READ_CHECKSUM_EN, `checksum` = 16'hFF00.
5. `start` pulsed at address 100 mid-sweep -> ignored, sweep continues to 511, exactly 512 transfers total.
6. `reset` asserted in HOLD at address 200 -> next cycle IDLE, `address_line` = 0, `data_valid` = 0, `cs_n` = 1; a new `start` sweeps again from address 0.

Source files
------------

// File: rtl/rom_read_sequencer.sv
// Sweeps every ROM address once per start, driving cs_n/oe_n with programmable wait states
// and handing each byte downstream over valid/ready. Optional ROM_READ_CHECKSUM_EN adds checksum_o.
module rom_read_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] address_line_o,
  output logic                  rom_cs_n_o,
  output logic                  rom_oe_n_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  busy_o,
`ifdef ROM_READ_CHECKSUM_EN
  output logic [15:0]           checksum_o,
`endif
  output logic                  done_o
);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(ACCESS_CYCLES - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] address_line_q;
  logic                  rom_cs_n_q;
  logic                  rom_oe_n_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [7:0]            wait_cnt_q;
`ifdef ROM_READ_CHECKSUM_EN
  logic [15:0]           checksum_q;
`endif

  // Outputs are registered together with the state they belong to, so they change on the
  // same edge as the state transition.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      address_line_q <= '0;
      rom_cs_n_q     <= 1'b1;
      rom_oe_n_q     <= 1'b1;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wait_cnt_q     <= '0;
`ifdef ROM_READ_CHECKSUM_EN
      checksum_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q        <= StSetup;
            address_line_q <= '0;
            rom_cs_n_q     <= 1'b0;
            rom_oe_n_q     <= 1'b1;
            busy_q         <= 1'b1;
`ifdef ROM_READ_CHECKSUM_EN
            checksum_q     <= '0;
`endif
          end
        end
        StSetup: begin
          state_q    <= StAccess;
          rom_oe_n_q <= 1'b0;
          wait_cnt_q <= '0;
        end
        StAccess: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (wait_cnt_q == LastCnt) begin
            state_q      <= StHold;
            rom_oe_n_q   <= 1'b1;
            data_out_q   <= rom_data_i;
            data_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (data_ready_i) begin
            data_valid_q <= 1'b0;
`ifdef ROM_READ_CHECKSUM_EN
            checksum_q   <= checksum_q + 16'(data_out_q);
`endif
            if (address_line_q == '1) begin
              state_q    <= StDone;
              rom_cs_n_q <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              state_q        <= StSetup;
              address_line_q <= address_line_q + ADDR_WIDTH'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign address_line_o = address_line_q;
  assign rom_cs_n_o     = rom_cs_n_q;
  assign rom_oe_n_o     = rom_oe_n_q;
  assign data_out_o     = data_out_q;
  assign data_valid_o   = data_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
`ifdef ROM_READ_CHECKSUM_EN
  assign checksum_o     = checksum_q;
`endif

endmodule
